// File: rtl/spi_flash_responder_pkg.sv
// Shared constants and state encoding for the SPI flash responder.
// The same encodings are meant to be reused by the matching reader.
package spi_flash_responder_pkg;

  localparam logic [7:0] CMD_READ_DEFAULT = 8'h03;
  localparam int         ADDR_W_DEFAULT   = 24;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_CMD,
    ST_ADDR,
    ST_DATA,
    ST_IGNORE
  } state_t;

endpackage

// File: rtl/spi_flash_responder_edge_sync.sv
// Two-flop synchronizer for a bundle of async pins, plus a delay stage on
// bit 0 that yields single-cycle rise/fall pulses for that bit.
module spi_flash_responder_edge_sync #(
  parameter int W = 3
) (
  input  logic         clk,
  input  logic [W-1:0] din,
  output logic [W-1:0] sync,
  output logic         rise,
  output logic         fall
);

  logic [W-1:0] meta;
  logic         dly;

  // No reset: the synchronizer must keep tracking the pins across a reset
  // so a still-asserted CS is not mistaken for a fresh assertion.
  always_ff @(posedge clk) begin
    meta <= din;
    sync <= meta;
    dly  <= sync[0];
  end

  assign rise = sync[0] & ~dly;
  assign fall = ~sync[0] & dly;

endmodule

// File: rtl/spi_flash_responder.sv
// Mode-0 SPI slave answering the serial-flash READ command from a byte-wide
// memory port; every SPI pin is oversampled in the clk domain.
module spi_flash_responder
  import spi_flash_responder_pkg::*;
#(
  parameter logic [7:0] CMD_READ = CMD_READ_DEFAULT,
  parameter int         ADDR_W   = ADDR_W_DEFAULT
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              spi_clk,
  input  logic              spi_cs,
  input  logic              spi_mosi,
  output logic              spi_miso,
  output logic [ADDR_W-1:0] mem_addr,
  output logic              mem_rd,
  input  logic [7:0]        mem_data,
  output logic              busy,
  output logic              cmd_err
);

  localparam int CNT_W = $clog2(ADDR_W);

  state_t            state, state_next;
  logic [2:0]        pins;
  logic              spi_rise, spi_fall;
  logic              cs_act, cs_prev, mosi;
  logic [CNT_W-1:0]  bit_cnt;
  logic [ADDR_W-2:0] rx_sh;
  logic [ADDR_W-1:0] rx_next;
  logic [7:0]        tx_sh;
  logic              load;
  logic              byte_end, addr_end;

  spi_flash_responder_edge_sync #(.W(3)) u_sync (
    .clk  (clk),
    .din  ({spi_mosi, spi_cs, spi_clk}),
    .sync (pins),
    .rise (spi_rise),
    .fall (spi_fall)
  );

  assign cs_act   = ~pins[1];
  assign mosi     = pins[2];
  assign rx_next  = {rx_sh, mosi};
  assign byte_end = (bit_cnt == CNT_W'(7));
  assign addr_end = (bit_cnt == CNT_W'(ADDR_W - 1));
  assign busy     = (state != ST_IDLE);

  always_ff @(posedge clk) begin
    if (reset) state <= ST_IDLE;
    else       state <= state_next;
  end

  // A transaction starts only on a CS assertion edge seen from IDLE.
  always_comb begin
    state_next = state;
    if (state != ST_IDLE && !cs_act) begin
      state_next = ST_IDLE;
    end else begin
      case (state)
        ST_IDLE: if (cs_act && !cs_prev) state_next = ST_CMD;
        ST_CMD:  if (spi_rise && byte_end)
                   state_next = (rx_next[7:0] == CMD_READ) ? ST_ADDR : ST_IGNORE;
        ST_ADDR: if (spi_rise && addr_end) state_next = ST_DATA;
        default: state_next = state;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      cs_prev  <= 1'b1;
      bit_cnt  <= '0;
      rx_sh    <= '0;
      tx_sh    <= '0;
      load     <= 1'b0;
      spi_miso <= 1'b0;
      mem_rd   <= 1'b0;
      mem_addr <= '0;
      cmd_err  <= 1'b0;
    end else begin
      cs_prev <= cs_act;
      mem_rd  <= 1'b0;
      cmd_err <= 1'b0;
      load    <= mem_rd;
      if (!cs_act || state == ST_IDLE) begin
        bit_cnt  <= '0;
        spi_miso <= 1'b0;
      end else begin
        case (state)
          ST_CMD: if (spi_rise) begin
            rx_sh   <= rx_next[ADDR_W-2:0];
            bit_cnt <= byte_end ? '0 : bit_cnt + CNT_W'(1);
            if (byte_end && rx_next[7:0] != CMD_READ) cmd_err <= 1'b1;
          end
          ST_ADDR: if (spi_rise) begin
            rx_sh <= rx_next[ADDR_W-2:0];
            if (addr_end) begin
              bit_cnt  <= '0;
              mem_addr <= rx_next;
              mem_rd   <= 1'b1;
            end else begin
              bit_cnt <= bit_cnt + CNT_W'(1);
            end
          end
          ST_DATA: begin
            // The fetch lands two cycles after a rise, always before the next fall.
            if (load) tx_sh <= mem_data;
            if (spi_fall) begin
              spi_miso <= tx_sh[7];
              tx_sh    <= {tx_sh[6:0], 1'b0};
            end
            if (spi_rise) begin
              if (byte_end) begin
                bit_cnt  <= '0;
                mem_addr <= mem_addr + ADDR_W'(1);
                mem_rd   <= 1'b1;
              end else begin
                bit_cnt <= bit_cnt + CNT_W'(1);
              end
            end
          end
          default: ;
        endcase
      end
    end
  end

endmodule

// File: tb/tb_spi_flash_responder.sv
// Directed bench for spi_flash_responder: a bit-banged SPI master, a memory
// returning addr[7:0]^8'h5A, and a fetch scoreboard checked every cycle.
module tb_spi_flash_responder;

  localparam int H = 4;  // SPI half-period in clk cycles (spi_clk = clk/8)

  logic        clk = 1'b0;
  logic        reset;
  logic        spi_clk, spi_cs, spi_mosi, spi_miso;
  logic [23:0] mem_addr;
  logic        mem_rd;
  logic [7:0]  mem_data;
  logic        busy, cmd_err;

  int          checks = 0;
  int          errors = 0;
  logic [23:0] exp_q[$];   // fetch addresses the model still requires
  logic [23:0] seen_q[$];  // every fetch address observed
  logic [7:0]  rx_q[$];    // bytes received by the master
  int          mode;       // 0 none, 1 selected, 2 quiet, 3 ignored command
  int          cmd_err_seen;

  // Clock/reset block
  always #5 clk = ~clk;

  spi_flash_responder dut (
    .clk      (clk),
    .reset    (reset),
    .spi_clk  (spi_clk),
    .spi_cs   (spi_cs),
    .spi_mosi (spi_mosi),
    .spi_miso (spi_miso),
    .mem_addr (mem_addr),
    .mem_rd   (mem_rd),
    .mem_data (mem_data),
    .busy     (busy),
    .cmd_err  (cmd_err)
  );

  always @(posedge clk) if (mem_rd) mem_data <= mem_addr[7:0] ^ 8'h5A;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h, required %h (t=%0t)", name, act, exp, $time);
    end
  endtask

  // Scoreboard / per-cycle compare
  always @(negedge clk) begin
    if (mem_rd) begin
      seen_q.push_back(mem_addr);
      if (exp_q.size() == 0) begin
        checks++;
        errors++;
        $display("FAIL unexpected_fetch: got mem_addr %h, required no fetch", mem_addr);
      end else begin
        check("fetch_addr", {8'h0, mem_addr}, {8'h0, exp_q.pop_front()});
      end
    end
    if (cmd_err) cmd_err_seen++;
    case (mode)
      1: check("busy_selected", {31'b0, busy}, 32'd1);
      2: begin
        check("busy_quiet", {31'b0, busy}, 32'd0);
        check("miso_quiet", {31'b0, spi_miso}, 32'd0);
      end
      3: begin
        check("busy_ignore", {31'b0, busy}, 32'd1);
        check("miso_ignore", {31'b0, spi_miso}, 32'd0);
      end
      default: ;
    endcase
  end

  // Driver tasks
  task automatic tick(input int n);
    repeat (n) @(negedge clk);
  endtask

  task automatic xfer_bit(input logic b, output logic r);
    spi_mosi = b;
    tick(H);
    spi_clk = 1'b1;
    r = spi_miso;
    tick(H);
    spi_clk = 1'b0;
  endtask

  task automatic send_bits(input logic [31:0] v, input int n);
    logic r;
    for (int i = n - 1; i >= 0; i--) xfer_bit(v[i], r);
  endtask

  task automatic recv_bytes(input int n);
    logic [7:0] b;
    logic       r;
    for (int k = 0; k < n; k++) begin
      for (int i = 7; i >= 0; i--) begin
        xfer_bit(1'b0, r);
        b[i] = r;
      end
      rx_q.push_back(b);
    end
  endtask

  task automatic cs_select();
    mode = 0;
    spi_cs = 1'b0;
    tick(4);
    mode = 1;
  endtask

  task automatic cs_release();
    mode = 0;
    tick(2);
    spi_cs = 1'b1;
    tick(6);
    mode = 2;
  endtask

  // Full READ of n bytes; the model expects fetches a .. a+n (last is the prefetch).
  task automatic do_read(input logic [23:0] a, input int n);
    logic [23:0] ai;
    for (int i = 0; i <= n; i++) begin
      ai = a + 24'(i);
      exp_q.push_back(ai);
    end
    rx_q.delete();
    seen_q.delete();
    cmd_err_seen = 0;
    cs_select();
    send_bits(32'h03, 8);
    send_bits({8'h0, a}, 24);
    recv_bytes(n);
    cs_release();
    check("fetches_drained", exp_q.size(), 0);
    check("no_cmd_err", cmd_err_seen, 0);
    check("rx_count", rx_q.size(), n);
    for (int i = 0; i < n && i < rx_q.size(); i++) begin
      ai = a + 24'(i);
      check("rx_byte_model", {24'h0, rx_q[i]}, {24'h0, ai[7:0] ^ 8'h5A});
    end
  endtask

  initial begin
    reset = 1'b1;
    spi_clk = 1'b0;
    spi_cs = 1'b1;
    spi_mosi = 1'b0;
    mode = 0;
    cmd_err_seen = 0;
    tick(3);
    reset = 1'b0;
    tick(1);
    check("rst_miso", {31'b0, spi_miso}, 32'd0);
    check("rst_mem_rd", {31'b0, mem_rd}, 32'd0);
    check("rst_mem_addr", {8'h0, mem_addr}, 32'd0);
    check("rst_busy", {31'b0, busy}, 32'd0);
    check("rst_cmd_err", {31'b0, cmd_err}, 32'd0);
    mode = 2;
    tick(4);

    // Single byte
    do_read(24'hABAFAB, 1);
    check("single_byte", {24'h0, rx_q[0]}, 32'hF1);
    check("single_addr", {8'h0, seen_q[0]}, 32'hABAFAB);

    // Burst of two
    do_read(24'hABAFAB, 2);
    check("burst_b0", {24'h0, rx_q[0]}, 32'hF1);
    check("burst_b1", {24'h0, rx_q[1]}, 32'hF6);
    check("burst_a1", {8'h0, seen_q[1]}, 32'hABAFAC);

    // Address wrap
    do_read(24'hFFFFFF, 2);
    check("wrap_b0", {24'h0, rx_q[0]}, 32'hA5);
    check("wrap_b1", {24'h0, rx_q[1]}, 32'h5A);
    check("wrap_a0", {8'h0, seen_q[0]}, 32'hFFFFFF);
    check("wrap_a1", {8'h0, seen_q[1]}, 32'h000000);

    // Unsupported command: no fetch, MISO held low, single error pulse
    cmd_err_seen = 0;
    cs_select();
    mode = 3;
    send_bits(32'h9F, 8);
    send_bits(32'h0, 32);
    cs_release();
    check("bad_cmd_err_pulses", cmd_err_seen, 1);
    check("bad_cmd_no_fetch", exp_q.size(), 0);

    // Early CS release after 13 address bits, then a fresh read
    cmd_err_seen = 0;
    cs_select();
    send_bits(32'h03, 8);
    send_bits(32'hABCDEF >> 11, 13);
    cs_release();
    check("early_no_cmd_err", cmd_err_seen, 0);
    do_read(24'h000010, 1);
    check("after_abort_byte", {24'h0, rx_q[0]}, 32'h4A);

    // Reset during DATA
    rx_q.delete();
    exp_q.push_back(24'h000020);
    exp_q.push_back(24'h000021);
    cs_select();
    send_bits(32'h03, 8);
    send_bits(32'h000020, 24);
    recv_bytes(1);
    send_bits(32'h0, 3);
    check("pre_reset_byte", {24'h0, rx_q[0]}, 32'h7A);
    mode = 0;
    reset = 1'b1;
    tick(1);
    reset = 1'b0;
    check("mid_rst_miso", {31'b0, spi_miso}, 32'd0);
    check("mid_rst_mem_rd", {31'b0, mem_rd}, 32'd0);
    check("mid_rst_mem_addr", {8'h0, mem_addr}, 32'd0);
    check("mid_rst_busy", {31'b0, busy}, 32'd0);
    check("mid_rst_cmd_err", {31'b0, cmd_err}, 32'd0);
    mode = 2;
    send_bits(32'h03, 8);  // bus traffic with CS still low must be ignored
    mode = 0;
    spi_cs = 1'b1;
    tick(6);
    mode = 2;
    check("post_reset_no_fetch", exp_q.size(), 0);
    do_read(24'h123456, 1);
    check("post_reset_byte", {24'h0, rx_q[0]}, 32'h0C);

    mode = 0;
    tick(4);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
